sequenciador_produto_escalar: RTL and testbench
===============================================

// Module: sequenciador_produto_escalar
// PURPOSE
//  Initiator for the 8-element dot-product engine: gathers 8 (a,b) operand pairs from a
//  valid/ready stream and drives them onto the engine's a0..a7/b0..b7 inputs.
//  Pulses start, waits for done and captures the 64-bit result. Presents the result on a
//  valid/ready output stream, so the SoC streams jobs without per-element CSR writes.
// PARAMETERS
//  TIMEOUT   64   max WAIT cycles before abort (used only with PRODSEQ_TIMEOUT_EN)
//  CNT_W     16   width of completed-job counter o_jobs
// PORTS
//  clk          in   1    system clock
//  rst          in   1    asynchronous reset, active-high; shared with the engine
//  i_clear      in   1    sync abort of a partial fill (FILL state only)
//  i_valid      in   1    operand pair valid
//  o_ready      out  1    operand pair accepted when i_valid & o_ready
//  i_a, i_b     in   32   signed operand pair (element index = arrival order)
//  o_start      out  1    1-cycle start pulse to engine
//  o_a0..o_a7   out  32   signed buffered a elements to engine
//  o_b0..o_b7   out  32   signed buffered b elements to engine
//  i_done       in   1    engine done
//  i_result     in   64   signed engine result
//  o_res_valid  out  1    result valid
//  i_res_ready  in   1    result consumed when o_res_valid & i_res_ready
//  o_res_data   out  64   signed captured result
//  o_busy       out  1    state != FILL
//  o_count      out  4    pairs loaded in current job (0..8)
//  o_jobs       out  CNT_W jobs completed, wraps at 2^CNT_W
//  o_timeout    out  1    sticky timeout flag
// BEHAVIOUR
//  Reset: state=FILL, o_ready=1, o_start=0, o_res_valid=0, o_res_data=0, o_count=0,
//   o_jobs=0, o_timeout=0, all o_a*/o_b*=0. Reset mid-job discards everything, no result.
//  FSM FILL->START->WAIT->OUT->FILL.
//  FILL: o_ready=1; each handshake writes buf[o_count] and increments o_count; on 8th
//   handshake go START. i_clear sets o_count=0 (wins over a same-cycle handshake; pair dropped).
//  START: o_ready=0, o_start=1 for exactly one cycle; o_a*/o_b* stable; go WAIT.
//  WAIT: o_start=0; on i_done=1 capture i_result into o_res_data, o_res_valid=1, go OUT.
//   i_done in any other state is ignored. i_clear is ignored outside FILL.
//  OUT: hold o_res_data/o_res_valid until i_res_ready; on handshake o_res_valid=0,
//   o_jobs+=1, o_count=0, go FILL. o_ready rises the cycle after the handshake.
//  Latency: 8th pair handshake -> o_start one cycle later. Engine done arrives ~9 cycles
//   after start; result valid in the cycle after i_done is sampled.
//  o_a*/o_b* keep the last job's values until overwritten during the next fill.
//  No arithmetic; the result passes through unmodified (signed 64-bit).
// CONFIGURATION
//  PRODSEQ_TIMEOUT_EN defined: WAIT counter counts cycles; if TIMEOUT cycles pass without
//   i_done, go OUT with o_res_data=64'h8000_0000_0000_0000 and set o_timeout (sticky until
//   rst); the job still counts in o_jobs. A late i_done is ignored.
//  Not defined: no counter, WAIT is unbounded, o_timeout tied 0.
// TESTING
//  a=1..8, b=1 x8, engine model -> o_start pulse 1 cycle, o_res_data=36, o_jobs=1.
//  a=1..8, b=1..8 back-to-back with i_valid held high -> 204, then second job 204, o_jobs=2.
//  a=-3 x8, b=5 x8 -> o_res_data=-120 (64'hFFFF_FFFF_FFFF_FF88).
//  i_res_ready low 5 cycles in OUT -> data/valid stable, o_ready=0, no 2nd start issued.
//  3 pairs, then i_clear, then 8 pairs a=2,b=2 -> result 32 (partial pairs discarded).
//  rst pulsed in WAIT -> all outputs reset; late i_done ignored; new job result correct.
//  PRODSEQ_TIMEOUT_EN, TIMEOUT=64, i_done tied 0 -> result 0x8000..0 after 64 WAIT
//   cycles, o_timeout=1.

Source files
------------

// File: rtl/sequenciador_produto_escalar_if.sv
//----------------------------------------------------------------------------
// sequenciador_produto_escalar_if : operand stream, engine and result stream
// bundle for the dot-product sequencer.  Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface sequenciador_produto_escalar_if #(
   parameter int CNT_W = 16
);
   logic                    i_clear;
   logic                    i_valid;
   logic                    o_ready;
   logic signed [31:0]      i_a;
   logic signed [31:0]      i_b;
   logic                    o_start;
   logic signed [31:0]      o_a0, o_a1, o_a2, o_a3, o_a4, o_a5, o_a6, o_a7;
   logic signed [31:0]      o_b0, o_b1, o_b2, o_b3, o_b4, o_b5, o_b6, o_b7;
   logic                    i_done;
   logic signed [63:0]      i_result;
   logic                    o_res_valid;
   logic                    i_res_ready;
   logic signed [63:0]      o_res_data;
   logic                    o_busy;
   logic [3:0]              o_count;
   logic [CNT_W-1:0]        o_jobs;
   logic                    o_timeout;

   // master: the sequencer itself; slave: the surrounding SoC / engine side
   modport master (
      input  i_clear, i_valid, i_a, i_b, i_done, i_result, i_res_ready,
      output o_ready, o_start,
      output o_a0, o_a1, o_a2, o_a3, o_a4, o_a5, o_a6, o_a7,
      output o_b0, o_b1, o_b2, o_b3, o_b4, o_b5, o_b6, o_b7,
      output o_res_valid, o_res_data, o_busy, o_count, o_jobs, o_timeout
   );

   modport slave (
      output i_clear, i_valid, i_a, i_b, i_done, i_result, i_res_ready,
      input  o_ready, o_start,
      input  o_a0, o_a1, o_a2, o_a3, o_a4, o_a5, o_a6, o_a7,
      input  o_b0, o_b1, o_b2, o_b3, o_b4, o_b5, o_b6, o_b7,
      input  o_res_valid, o_res_data, o_busy, o_count, o_jobs, o_timeout
   );
endinterface

`default_nettype wire

// File: rtl/sequenciador_produto_escalar.sv
//----------------------------------------------------------------------------
// sequenciador_produto_escalar : gathers 8 operand pairs, starts the dot-product
// engine, returns its result on a stream. Optional WAIT watchdog: PRODSEQ_TIMEOUT_EN.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module sequenciador_produto_escalar #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   sequenciador_produto_escalar_if.master     bus
);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         count_q, count_d;
   logic signed [31:0] a_q [8];
   logic signed [31:0] a_d [8];
   logic signed [31:0] b_q [8];
   logic signed [31:0] b_d [8];
   logic signed [63:0] res_q, res_d;
   logic [CNT_W-1:0]   jobs_q, jobs_d;
   logic               timeout_q, timeout_d;
   logic               wait_expired;

`ifdef PRODSEQ_TIMEOUT_EN
   localparam int WCNT_W = $clog2(TIMEOUT + 1);
   logic [WCNT_W-1:0] wcnt_q;

   assign wait_expired = (wcnt_q == WCNT_W'(TIMEOUT - 1));

   // Counts cycles spent in WAIT; restarts from zero on every entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_q <= '0;
      end else if (state_q == S_WAIT) begin
         wcnt_q <= wcnt_q + 1'b1;
      end else begin
         wcnt_q <= '0;
      end
   end
`else
   assign wait_expired = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FILL;
         count_q   <= '0;
         a_q       <= '{default: '0};
         b_q       <= '{default: '0};
         res_q     <= '0;
         jobs_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         a_q       <= a_d;
         b_q       <= b_d;
         res_q     <= res_d;
         jobs_q    <= jobs_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      jobs_d    = jobs_q;
      timeout_d = timeout_q;
      case (state_q)
         S_FILL: begin
            // Clear beats a same-cycle handshake: that pair is dropped.
            if (bus.i_clear) begin
               count_d = '0;
            end else if (bus.i_valid) begin
               a_d[count_q[2:0]] = bus.i_a;
               b_d[count_q[2:0]] = bus.i_b;
               count_d           = count_q + 4'd1;
               if (count_q == 4'd7) begin
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.i_done) begin
               res_d   = bus.i_result;
               state_d = S_OUT;
            end else if (wait_expired) begin
               res_d     = 64'sh8000_0000_0000_0000;
               timeout_d = 1'b1;
               state_d   = S_OUT;
            end
         end
         S_OUT: begin
            if (bus.i_res_ready) begin
               jobs_d  = jobs_q + 1'b1;
               count_d = '0;
               state_d = S_FILL;
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   assign bus.o_ready     = (state_q == S_FILL);
   assign bus.o_start     = (state_q == S_START);
   assign bus.o_res_valid = (state_q == S_OUT);
   assign bus.o_busy      = (state_q != S_FILL);
   assign bus.o_res_data  = res_q;
   assign bus.o_count     = count_q;
   assign bus.o_jobs      = jobs_q;
   assign bus.o_timeout   = timeout_q;

   assign bus.o_a0 = a_q[0];
   assign bus.o_a1 = a_q[1];
   assign bus.o_a2 = a_q[2];
   assign bus.o_a3 = a_q[3];
   assign bus.o_a4 = a_q[4];
   assign bus.o_a5 = a_q[5];
   assign bus.o_a6 = a_q[6];
   assign bus.o_a7 = a_q[7];
   assign bus.o_b0 = b_q[0];
   assign bus.o_b1 = b_q[1];
   assign bus.o_b2 = b_q[2];
   assign bus.o_b3 = b_q[3];
   assign bus.o_b4 = b_q[4];
   assign bus.o_b5 = b_q[5];
   assign bus.o_b6 = b_q[6];
   assign bus.o_b7 = b_q[7];

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_produto_escalar.sv
//----------------------------------------------------------------------------
// tb_sequenciador_produto_escalar : scoreboard bench with an engine model.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_sequenciador_produto_escalar;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sequenciador_produto_escalar_if #(.CNT_W(16)) bus ();

   sequenciador_produto_escalar #(
      .TIMEOUT (64),
      .CNT_W   (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int     checks = 0;
   int     errors = 0;
   longint exp_q[$];
   int     pa[$];
   int     pb[$];
   int     jobs_model = 0;
   bit     stall_force = 1'b0;
   bit     eng_mute = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Engine model: result = sum of products of the presented buffers, done 9 cycles after start.
   initial begin
      longint eng_res;
      int     eng_cnt;
      bit     prev_start;
      eng_res = 0; eng_cnt = 0; prev_start = 1'b0;
      bus.i_done = 1'b0; bus.i_result = '0;
      forever begin
         @(negedge clk);
         bus.i_done = 1'b0;
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0 && !eng_mute) begin
               bus.i_done   = 1'b1;
               bus.i_result = eng_res;
            end
         end
         if (bus.o_start === 1'b1) begin
            chk("start_single_cycle", 64'(prev_start), 64'd0);
            eng_res = longint'(bus.o_a0) * longint'(bus.o_b0) + longint'(bus.o_a1) * longint'(bus.o_b1)
                    + longint'(bus.o_a2) * longint'(bus.o_b2) + longint'(bus.o_a3) * longint'(bus.o_b3)
                    + longint'(bus.o_a4) * longint'(bus.o_b4) + longint'(bus.o_a5) * longint'(bus.o_b5)
                    + longint'(bus.o_a6) * longint'(bus.o_b6) + longint'(bus.o_a7) * longint'(bus.o_b7);
            eng_cnt = 9;
         end
         prev_start = (bus.o_start === 1'b1);
      end
   end

   // Monitor: drives result-ready and scores every result handshake.
   initial begin
      longint e;
      bus.i_res_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.i_res_ready = 1'b0;
         end else begin
            bus.i_res_ready = stall_force ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (bus.o_res_valid === 1'b1 && bus.i_res_ready) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_result: got 0x%h expected none", bus.o_res_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("result", bus.o_res_data, e);
               end
               chk("jobs_count", 64'(bus.o_jobs), 64'(jobs_model & 32'hFFFF));
               jobs_model++;
            end
         end
      end
   end

   // Reference: result is the plain dot product of the last 8 pairs accepted since a clear.
   task automatic send_pair(input int a, input int b);
      int     n;
      longint s;
      n = 0;
      bus.i_valid = 1'b1; bus.i_a = a; bus.i_b = b;
      while (bus.o_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         checks++; errors++;
         $display("FAIL send_timeout: got o_ready=%b expected 1", bus.o_ready);
      end else begin
         pa.push_back(a); pb.push_back(b);
      end
      @(negedge clk);
      if (pa.size() == 8) begin
         s = 0;
         for (int i = 0; i < 8; i++) s += longint'(pa[i]) * longint'(pb[i]);
         exp_q.push_back(s);
         pa.delete(); pb.delete();
         chk("start_latency", 64'(bus.o_start), 64'd1);
         chk("count_full", 64'(bus.o_count), 64'd8);
      end else begin
         chk("count", 64'(bus.o_count), 64'(pa.size()));
      end
   endtask

   task automatic clear_fill();
      bus.i_clear = 1'b1; bus.i_valid = 1'b1; bus.i_a = 32'd99; bus.i_b = 32'd99;
      @(negedge clk);
      bus.i_clear = 1'b0; bus.i_valid = 1'b0;
      pa.delete(); pb.delete();
      chk("clear_count", 64'(bus.o_count), 64'd0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.i_valid = 1'b0;
      while ((exp_q.size() != 0 || bus.o_busy !== 1'b0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
   endtask

   task automatic check_reset_state();
      chk("rst_ready",     64'(bus.o_ready),     64'd1);
      chk("rst_start",     64'(bus.o_start),     64'd0);
      chk("rst_res_valid", 64'(bus.o_res_valid), 64'd0);
      chk("rst_res_data",  bus.o_res_data,       64'd0);
      chk("rst_count",     64'(bus.o_count),     64'd0);
      chk("rst_jobs",      64'(bus.o_jobs),      64'd0);
      chk("rst_timeout",   64'(bus.o_timeout),   64'd0);
      chk("rst_busy",      64'(bus.o_busy),      64'd0);
      chk("rst_a0",        64'(bus.o_a0),        64'd0);
      chk("rst_b7",        64'(bus.o_b7),        64'd0);
   endtask

   initial begin
      logic [63:0] snap;
      int          n;
      rst = 1'b1;
      bus.i_clear = 1'b0; bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0;
      repeat (2) @(negedge clk);
      check_reset_state();
      rst = 1'b0;
      @(negedge clk);

      for (int i = 1; i <= 8; i++) send_pair(i, 1);
      drain();
      chk("jobs_after_first", 64'(bus.o_jobs), 64'd1);

      for (int j = 0; j < 2; j++)
         for (int i = 1; i <= 8; i++) send_pair(i, i);
      drain();
      chk("jobs_after_b2b", 64'(bus.o_jobs), 64'd3);

      for (int i = 0; i < 8; i++) send_pair(-3, 5);
      drain();

      // Result held while the consumer stalls; clear and new pairs are ignored.
      stall_force = 1'b1;
      for (int i = 0; i < 8; i++) send_pair($urandom, $urandom);
      n = 0;
      while (bus.o_res_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("stall_valid_seen", 64'(bus.o_res_valid), 64'd1);
      snap = bus.o_res_data;
      bus.i_valid = 1'b1; bus.i_a = 32'd7; bus.i_b = 32'd7;
      for (int c = 0; c < 5; c++) begin
         bus.i_clear = (c == 2);
         @(negedge clk);
         chk("stall_valid", 64'(bus.o_res_valid), 64'd1);
         chk("stall_data",  bus.o_res_data,       snap);
         chk("stall_ready", 64'(bus.o_ready),     64'd0);
         chk("stall_start", 64'(bus.o_start),     64'd0);
      end
      bus.i_clear = 1'b0; bus.i_valid = 1'b0;
      chk("stall_count", 64'(bus.o_count), 64'd8);
      stall_force = 1'b0;
      drain();

      for (int i = 0; i < 3; i++) send_pair($urandom_range(0, 50), $urandom_range(0, 50));
      clear_fill();
      for (int i = 0; i < 8; i++) send_pair(2, 2);
      drain();

      // Reset while the engine is working; its late done must be ignored.
      for (int i = 0; i < 8; i++) send_pair($urandom, $urandom);
      bus.i_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("wait_busy", 64'(bus.o_busy), 64'd1);
      rst = 1'b1;
      exp_q.delete(); pa.delete(); pb.delete(); jobs_model = 0;
      @(negedge clk);
      check_reset_state();
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("late_done_busy",  64'(bus.o_busy),      64'd0);
      chk("late_done_valid", 64'(bus.o_res_valid), 64'd0);
      for (int i = 0; i < 8; i++) send_pair($urandom_range(0, 1000) - 500, $urandom_range(0, 1000) - 500);
      drain();
      chk("jobs_after_reset", 64'(bus.o_jobs), 64'd1);

      for (int j = 0; j < 6; j++) begin
         for (int i = 0; i < 8; i++) begin
            send_pair($urandom, $urandom);
            if (pa.size() > 0 && $urandom_range(0, 9) == 0) clear_fill();
            if ($urandom_range(0, 2) == 0) begin
               bus.i_valid = 1'b0;
               repeat ($urandom_range(1, 3)) @(negedge clk);
            end
         end
      end
      bus.i_valid = 1'b0;
      while (pa.size() != 0) send_pair($urandom, $urandom);
      drain();

`ifdef PRODSEQ_TIMEOUT_EN
      eng_mute = 1'b1;
      for (int i = 0; i < 8; i++) send_pair(1, 1);
      void'(exp_q.pop_back());
      exp_q.push_back(64'sh8000_0000_0000_0000);
      drain();
      chk("timeout_flag", 64'(bus.o_timeout), 64'd1);
      eng_mute = 1'b0;
`endif

      chk("jobs_final", 64'(bus.o_jobs), 64'(jobs_model & 32'hFFFF));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
